// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encoding, reset
// values, default geometry and the 2-bit saturating counter update.
package branch_predictor_pkg;

   // Default table geometry: 2^6 = 64 entries, indexed by word address.
   localparam int PKG_INDEX_BITS = 6;

   // Byte distance from a branch to its not-taken fall-through (the
   // instruction after the delay slot).
   localparam logic [31:0] DELAY_SLOT_DEFAULT = 32'd8;

   // 2-bit counter encoding: the MSB is the taken/not-taken prediction.
   typedef enum logic [1:0] {
      CNT_STRONG_NT = 2'b00,
      CNT_WEAK_NT   = 2'b01,
      CNT_WEAK_T    = 2'b10,
      CNT_STRONG_T  = 2'b11
   } bht_cnt_e;

   // Counters come out of reset weakly not-taken.
   localparam logic [1:0] BHT_RESET = 2'b01;

   // Saturating increment on taken, saturating decrement on not-taken.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      res = cnt;
      if (taken) begin
         if (cnt != 2'b11) res = cnt + 2'd1;
      end else begin
         if (cnt != 2'b00) res = cnt - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// The slave modport is the predictor; the master modport is the pipeline.
interface branch_predictor_if;

   // Fetch side
   logic        FLUSH;
   logic        Stall_IN;
   logic [31:0] Fetch_PC_IN;
   logic        Predict_Taken;
   logic [31:0] Predict_Target;
   logic        Branch_prediction_OUT;
   logic [31:0] Branch_prediction_addr_OUT;
   logic [1:0]  Branch_predictions_OUT;

   // Resolve side
   logic        Resolve_Valid_IN;
   logic [31:0] Resolve_PC_IN;
   logic        Request_Alt_PC;
   logic [31:0] Alt_PC;
   logic        Branch_prediction_IN;
   logic [31:0] Branch_prediction_addr_IN;
   logic [1:0]  Branch_predictions_IN;
   logic        Mispredict_OUT;
   logic [31:0] Redirect_PC_OUT;
   logic [31:0] Branch_count_OUT;
   logic [31:0] Mispredict_count_OUT;

   modport slave (
      input  FLUSH, Stall_IN, Fetch_PC_IN,
      output Predict_Taken, Predict_Target,
      output Branch_prediction_OUT, Branch_prediction_addr_OUT, Branch_predictions_OUT,
      input  Resolve_Valid_IN, Resolve_PC_IN, Request_Alt_PC, Alt_PC,
      input  Branch_prediction_IN, Branch_prediction_addr_IN, Branch_predictions_IN,
      output Mispredict_OUT, Redirect_PC_OUT, Branch_count_OUT, Mispredict_count_OUT
   );

   modport master (
      output FLUSH, Stall_IN, Fetch_PC_IN,
      input  Predict_Taken, Predict_Target,
      input  Branch_prediction_OUT, Branch_prediction_addr_OUT, Branch_predictions_OUT,
      output Resolve_Valid_IN, Resolve_PC_IN, Request_Alt_PC, Alt_PC,
      output Branch_prediction_IN, Branch_prediction_addr_IN, Branch_predictions_IN,
      input  Mispredict_OUT, Redirect_PC_OUT, Branch_count_OUT, Mispredict_count_OUT
   );

endinterface

// File: rtl/branch_predictor_bht_btb_table.sv
// Direct-mapped BTB (valid/tag/target) plus 2-bit BHT. One asynchronous
// read port for fetch lookup and one write port for branch resolution.
// Valid bits and counters are cleared by reset, so the arrays are flops.
module bht_btb_table
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS = PKG_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // fetch lookup
   input  logic [INDEX_BITS-1:0] rd_idx_i,
   output logic                  rd_valid_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic [31:0]           rd_target_o,
   output logic [1:0]            rd_cnt_o,
   // resolve update
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_idx_i,
   input  logic [1:0]            wr_cnt_i,
   input  logic                  wr_btb_en_i,
   input  logic [TAG_BITS-1:0]   wr_tag_i,
   input  logic [31:0]           wr_target_i
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic                valid_q  [ENTRIES];
   logic [1:0]          bht_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];

   // Lookup reads the pre-update state; a write lands at the next edge.
   assign rd_valid_o  = valid_q[rd_idx_i];
   assign rd_tag_o    = tag_q[rd_idx_i];
   assign rd_target_o = target_q[rd_idx_i];
   assign rd_cnt_o    = bht_q[rd_idx_i];

   // Valid bits and counters: reset-clear, then written on resolve.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            bht_q[i]   <= BHT_RESET;
         end
      end else if (wr_en_i) begin
         bht_q[wr_idx_i] <= wr_cnt_i;
         if (wr_btb_en_i) valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag/target payload needs no reset: it is qualified by the valid bit.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && wr_btb_en_i) begin
         tag_q[wr_idx_i]    <= wr_tag_i;
         target_q[wr_idx_i] <= wr_target_i;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor top: fetch-side lookup with registered IF/ID prediction
// fields, and resolve-side table update, mispredict detection, redirect
// and statistics counters.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int          INDEX_BITS = PKG_INDEX_BITS,
   parameter logic [31:0] DELAY_SLOT = DELAY_SLOT_DEFAULT
) (
   input  logic                CLK,
   input  logic                RESET,
   branch_predictor_if.slave   bp
);

   localparam int TAG_BITS = 30 - INDEX_BITS;

   // Lookup side
   logic [INDEX_BITS-1:0] fetch_idx;
   logic [TAG_BITS-1:0]   fetch_tag;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [31:0]           rd_target;
   logic [1:0]            rd_cnt;
   logic                  hit;
   logic                  pred_taken;
   logic [31:0]           pred_target;

   // Resolve side
   logic                  resolve_accept;
   logic [INDEX_BITS-1:0] res_idx;
   logic [TAG_BITS-1:0]   res_tag;
   logic [1:0]            res_cnt;
   logic [31:0]           actual_pc;
   logic                  mispredict;

   // Registered state
   logic        pred_taken_q,  pred_taken_d;
   logic [31:0] pred_target_q, pred_target_d;
   logic [1:0]  pred_cnt_q,    pred_cnt_d;
   logic        mispredict_q,  mispredict_d;
   logic [31:0] redirect_q,    redirect_d;
   logic [31:0] branch_cnt_q,  branch_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   assign fetch_idx = bp.Fetch_PC_IN[INDEX_BITS+1:2];
   assign fetch_tag = bp.Fetch_PC_IN[31:INDEX_BITS+2];
   assign res_idx   = bp.Resolve_PC_IN[INDEX_BITS+1:2];
   assign res_tag   = bp.Resolve_PC_IN[31:INDEX_BITS+2];

   bht_btb_table #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_table (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .rd_idx_i    (fetch_idx),
      .rd_valid_o  (rd_valid),
      .rd_tag_o    (rd_tag),
      .rd_target_o (rd_target),
      .rd_cnt_o    (rd_cnt),
      .wr_en_i     (resolve_accept),
      .wr_idx_i    (res_idx),
      .wr_cnt_i    (res_cnt),
      .wr_btb_en_i (bp.Request_Alt_PC),
      .wr_tag_i    (res_tag),
      .wr_target_i (bp.Alt_PC)
   );

   // Fetch lookup: predict taken only on a tag hit with a taken counter.
   always_comb begin
      hit         = rd_valid && (rd_tag == fetch_tag);
      pred_taken  = hit && rd_cnt[1];
      pred_target = pred_taken ? rd_target : (bp.Fetch_PC_IN + 32'd4);
   end

   // Resolve: a resolve arriving while a redirect is in flight is wrong-path.
   always_comb begin
      resolve_accept = bp.Resolve_Valid_IN && !mispredict_q;
      res_cnt        = sat_update(bp.Branch_predictions_IN, bp.Request_Alt_PC);
      actual_pc      = bp.Request_Alt_PC ? bp.Alt_PC : (bp.Resolve_PC_IN + DELAY_SLOT);
      mispredict     = (bp.Branch_prediction_IN != bp.Request_Alt_PC) ||
                       (bp.Branch_prediction_IN && bp.Request_Alt_PC &&
                        (bp.Branch_prediction_addr_IN != bp.Alt_PC));
   end

   // Next-state for IF/ID prediction fields and resolve bookkeeping.
   always_comb begin
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      pred_cnt_d    = pred_cnt_q;
      if (bp.FLUSH || mispredict_q) begin
         pred_taken_d  = 1'b0;
         pred_target_d = 32'd0;
         pred_cnt_d    = 2'b00;
      end else if (!bp.Stall_IN) begin
         pred_taken_d  = pred_taken;
         pred_target_d = pred_target;
         pred_cnt_d    = rd_cnt;
      end

      mispredict_d  = resolve_accept && mispredict;
      redirect_d    = (resolve_accept && mispredict) ? actual_pc : redirect_q;
      branch_cnt_d  = branch_cnt_q + {31'd0, resolve_accept};
      mispred_cnt_d = mispred_cnt_q + {31'd0, resolve_accept && mispredict};
   end

   // State registers; reset overrides everything.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pred_taken_q  <= 1'b0;
         pred_target_q <= 32'd0;
         pred_cnt_q    <= 2'b00;
         mispredict_q  <= 1'b0;
         redirect_q    <= 32'd0;
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         pred_cnt_q    <= pred_cnt_d;
         mispredict_q  <= mispredict_d;
         redirect_q    <= redirect_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bp.Predict_Taken              = pred_taken;
   assign bp.Predict_Target             = pred_target;
   assign bp.Branch_prediction_OUT      = pred_taken_q;
   assign bp.Branch_prediction_addr_OUT = pred_target_q;
   assign bp.Branch_predictions_OUT     = pred_cnt_q;
   assign bp.Mispredict_OUT             = mispredict_q;
   assign bp.Redirect_PC_OUT            = redirect_q;
   assign bp.Branch_count_OUT           = branch_cnt_q;
   assign bp.Mispredict_count_OUT       = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed expectations checked
// with immediate assertions, one line per transaction.
module tb_branch_predictor;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   int   total = 0;
   int   bad   = 0;

   branch_predictor_if bp_if ();

   branch_predictor dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bp    (bp_if.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic resolve(input logic v, input logic [31:0] pc, input logic taken,
                          input logic [31:0] alt, input logic pin,
                          input logic [31:0] pa, input logic [1:0] snap);
      bp_if.Resolve_Valid_IN          = v;
      bp_if.Resolve_PC_IN             = pc;
      bp_if.Request_Alt_PC            = taken;
      bp_if.Alt_PC                    = alt;
      bp_if.Branch_prediction_IN      = pin;
      bp_if.Branch_prediction_addr_IN = pa;
      bp_if.Branch_predictions_IN     = snap;
   endtask

   task automatic chk_regs(input string tag, input logic t, input logic [31:0] a, input logic [1:0] c);
      chk({tag, "_bp"},   {31'd0, bp_if.Branch_prediction_OUT}, {31'd0, t});
      chk({tag, "_addr"}, bp_if.Branch_prediction_addr_OUT, a);
      chk({tag, "_cnt"},  {30'd0, bp_if.Branch_predictions_OUT}, {30'd0, c});
   endtask

   task automatic chk_res(input string tag, input logic m, input logic [31:0] r,
                          input logic [31:0] bc, input logic [31:0] mc);
      chk({tag, "_misp"},  {31'd0, bp_if.Mispredict_OUT}, {31'd0, m});
      chk({tag, "_redir"}, bp_if.Redirect_PC_OUT, r);
      chk({tag, "_bcnt"},  bp_if.Branch_count_OUT, bc);
      chk({tag, "_mcnt"},  bp_if.Mispredict_count_OUT, mc);
   endtask

   task automatic chk_look(input string tag, input logic t, input logic [31:0] a);
      chk({tag, "_pt"},  {31'd0, bp_if.Predict_Taken}, {31'd0, t});
      chk({tag, "_ptg"}, bp_if.Predict_Target, a);
   endtask

   initial begin
      bp_if.FLUSH       = 1'b0;
      bp_if.Stall_IN    = 1'b0;
      bp_if.Fetch_PC_IN = 32'h0;
      resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);

      // Reset
      tick(); tick();
      chk_regs("rst", 1'b0, 32'h0, 2'b00);
      chk_res("rst", 1'b0, 32'h0, 32'd0, 32'd0);
      $display("txn reset");
      RESET = 1'b0;

      // Cold lookup
      bp_if.Fetch_PC_IN = 32'h0040_0020;
      #1 chk_look("cold", 1'b0, 32'h0040_0024);
      tick();
      chk_regs("cold_reg", 1'b0, 32'h0040_0024, 2'b01);
      $display("txn cold lookup pc=00400020");

      // Taken resolve, predicted not-taken -> mispredict
      resolve(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0028, 2'b01);
      tick();
      resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      chk_res("train", 1'b1, 32'h0040_0100, 32'd1, 32'd1);
      chk_look("train_look", 1'b1, 32'h0040_0100);
      tick();
      chk_res("train_after", 1'b0, 32'h0040_0100, 32'd1, 32'd1);
      chk_regs("train_clr", 1'b0, 32'h0, 2'b00);
      tick();
      chk_regs("train_reg", 1'b1, 32'h0040_0100, 2'b10);
      $display("txn resolve taken pc=00400020 -> mispredict");

      // Not-taken resolve, predicted taken -> mispredict, counter back to 01
      resolve(1'b1, 32'h0040_0020, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100, 2'b10);
      tick();
      resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      chk_res("nt", 1'b1, 32'h0040_0028, 32'd2, 32'd2);
      chk_look("nt_look", 1'b0, 32'h0040_0024);
      tick();
      chk({"nt_pulse"}, {31'd0, bp_if.Mispredict_OUT}, 32'd0);
      $display("txn resolve not-taken pc=00400020 -> mispredict");

      // Saturation: four correctly predicted taken resolves with snapshot 11
      resolve(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100, 2'b11);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_res("sat", 1'b0, 32'h0040_0028, 32'd3 + k, 32'd2);
         $display("txn saturate step %0d", k);
      end
      resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      chk_look("sat_look", 1'b1, 32'h0040_0100);
      tick();
      chk_regs("sat_reg", 1'b1, 32'h0040_0100, 2'b11);

      // Back-to-back mispredicting resolves: second is wrong-path
      resolve(1'b1, 32'h0040_0040, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0044, 2'b01);
      tick();
      chk_res("b2b_first", 1'b1, 32'h0040_0200, 32'd7, 32'd3);
      resolve(1'b1, 32'h0040_0060, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0064, 2'b01);
      tick();
      resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
      chk_res("b2b_second", 1'b0, 32'h0040_0200, 32'd7, 32'd3);
      bp_if.Fetch_PC_IN = 32'h0040_0060;
      #1 chk_look("b2b_noupd", 1'b0, 32'h0040_0064);
      $display("txn back-to-back resolves");

      // Aliasing: same index, different tag
      bp_if.Fetch_PC_IN = 32'h0040_1020;
      #1 chk_look("alias", 1'b0, 32'h0040_1024);
      bp_if.Fetch_PC_IN = 32'h0040_0020;
      #1 chk_look("alias_orig", 1'b1, 32'h0040_0100);
      $display("txn aliasing");

      // FLUSH clears, then capture, then Stall holds
      bp_if.FLUSH = 1'b1;
      tick();
      chk_regs("flush", 1'b0, 32'h0, 2'b00);
      bp_if.FLUSH = 1'b0;
      tick();
      chk_regs("cap", 1'b1, 32'h0040_0100, 2'b11);
      bp_if.Stall_IN    = 1'b1;
      bp_if.Fetch_PC_IN = 32'h0040_1020;
      tick();
      chk_regs("stall", 1'b1, 32'h0040_0100, 2'b11);
      bp_if.Stall_IN = 1'b0;
      $display("txn flush/stall");

      // Mid-run reset clears everything including the tables
      bp_if.Fetch_PC_IN = 32'h0040_0020;
      RESET = 1'b1;
      tick();
      chk_regs("rst2", 1'b0, 32'h0, 2'b00);
      chk_res("rst2", 1'b0, 32'h0, 32'd0, 32'd0);
      RESET = 1'b0;
      #1 chk_look("rst2_look", 1'b0, 32'h0040_0024);
      tick();
      chk_regs("rst2_reg", 1'b0, 32'h0040_0024, 2'b01);
      $display("txn mid-run reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side producer and resolution-side consumer of the branch-prediction fields that travel down the pipeline: Branch_prediction, Branch_prediction_addr, Branch_predictions[1:0].
- Looks up a direct-mapped BTB plus a 2-bit saturating-counter BHT at fetch, then registers the prediction into IF/ID.
- Consumes the resolved Request_Alt_PC/Alt_PC and prediction fields coming back from EXE.
- Updates the tables, detects mispredicts, and issues a registered redirect/flush to fetch.

Parameters:
INDEX_BITS, 6, log2 of table entries (64); index = PC[INDEX_BITS+1:2]
DELAY_SLOT, 8, byte offset from branch PC to the not-taken fall-through (MIPS delay slot)

Ports:
CLK  in  1  clock, all state updates on posedge
RESET  in  1  synchronous, active-high reset
FLUSH  in  1  external pipeline flush; clears registered prediction outputs
Stall_IN  in  1  IF/ID hold; registered prediction outputs keep their value
Fetch_PC_IN  in  32  PC being fetched this cycle
Predict_Taken  out  1  combinational: fetch should take predicted target
Predict_Target  out  32  combinational: predicted next PC (BTB target on taken, else Fetch_PC_IN+4)
Branch_prediction_OUT  out  1  registered Predict_Taken for IF/ID
Branch_prediction_addr_OUT  out  32  registered Predict_Target
Branch_predictions_OUT  out  2  registered BHT counter snapshot at fetch
Resolve_Valid_IN  in  1  EXE resolved a branch/jump this cycle
Resolve_PC_IN  in  32  PC of the resolved branch
Request_Alt_PC  in  1  actual outcome: taken
Alt_PC  in  32  actual taken target
Branch_prediction_IN  in  1  prediction carried with the branch
Branch_prediction_addr_IN  in  32  predicted next PC carried with the branch
Branch_predictions_IN  in  2  counter snapshot carried with the branch
Mispredict_OUT  out  1  registered one-cycle pulse: redirect and flush younger stages
Redirect_PC_OUT  out  32  registered correct next PC, valid while Mispredict_OUT
Branch_count_OUT  out  32  resolved branches counted; wraps at 2^32
Mispredict_count_OUT  out  32  mispredicts counted; wraps at 2^32

Behaviour:
- Reset (RESET high at posedge):
  - All BHT counters = 2'b01; all BTB valid = 0.
  - All registered outputs and both counts = 0.
  - Reset has priority over every other input.
- Lookup:
  - idx = Fetch_PC_IN[INDEX_BITS+1:2]; tag = Fetch_PC_IN[31:INDEX_BITS+2].
  - hit = valid[idx] && tag match.
  - Predict_Taken = hit && bht[idx][1].
  - Predict_Target = Predict_Taken ? btb_target[idx] : Fetch_PC_IN+4.
  - Lookup reads pre-update state; no same-cycle bypass from a resolve.
- Registered prediction, 1-cycle latency, priority RESET > FLUSH > Stall_IN:
  - FLUSH or Mispredict_OUT: clear to 0.
  - Stall_IN: hold.
  - Otherwise: capture Predict_Taken, Predict_Target, bht[idx].
- Resolve is accepted when Resolve_Valid_IN && !Mispredict_OUT. A resolve in the cycle Mispredict_OUT is high is wrong-path: no update, no count, no pulse.
- On an accepted resolve:
  - ridx from Resolve_PC_IN.
  - bht[ridx] = saturating(Branch_predictions_IN + 1) if taken, else saturating(-1), clamped 0..3. The update uses the carried snapshot, not the current entry.
  - If taken: write BTB valid=1, tag, target=Alt_PC.
  - If not taken: BTB entry unchanged.
- Actual next PC = Request_Alt_PC ? Alt_PC : Resolve_PC_IN+DELAY_SLOT.
- Mispredict when Branch_prediction_IN != Request_Alt_PC, or when both are taken and Branch_prediction_addr_IN != Alt_PC.
- On mispredict, next cycle: Mispredict_OUT=1 and Redirect_PC_OUT = actual next PC. Otherwise Mispredict_OUT=0 and Redirect_PC_OUT holds.
- Branch_count_OUT += 1 per accepted resolve; Mispredict_count_OUT += 1 per mispredict. Both wrap silently.
- Simultaneous resolve and lookup to the same index: lookup sees the old value; the write lands at posedge.
- FLUSH does not touch tables, counts, or the mispredict logic.

Decomposition:
- Shared package:
  - BHT_RESET = 2'b01
  - counter encoding (00/01 not taken, 10/11 taken)
  - DELAY_SLOT
  - sat_update(counter, taken) function
- One sub-module, bht_btb_table:
  - Arrays plus reset-clear.
  - Async read port for fetch; single write port for resolve.

Test Plan:
- Reset then Fetch_PC_IN=0x00400020 -> Predict_Taken=0, Predict_Target=0x00400024; one cycle later Branch_predictions_OUT=01.
- Resolve PC=0x00400020, taken, Alt_PC=0x00400100, prediction 0/snapshot 01 -> next cycle Mispredict_OUT=1, Redirect_PC_OUT=0x00400100, counts 1/1; refetch 0x00400020 -> Predict_Taken=1, Predict_Target=0x00400100.
- Same branch resolved not-taken with prediction 1, snapshot 10, addr 0x00400100 -> counter 01, Redirect_PC_OUT=0x00400028, Mispredict_OUT pulse.
- Saturation: four taken resolves with snapshot 11 -> counter stays 11, no mispredict when the carried addr equals Alt_PC.
- Resolve_Valid_IN high in two consecutive cycles, both mispredicting -> only the first counted and pulsed; the second is ignored.
- Aliasing: PC 0x00400020 trained taken, fetch 0x00401020 (same idx, different tag) -> miss, Predict_Taken=0; RESET mid-run -> all outputs 0, table cleared.
